vend_controller: RTL and testbench

Multi-product vending sequencer that sits between the coin acceptor/front panel and the dispense mechanism. It accumulates credit from quarter and dollar pulses and accepts a product selection. It drives a request/acknowledge handshake to the dispenser and then pays out change one quarter at a time. A dispenser timeout aborts the vend and refunds the full credit.

---
 rtl/vend_controller.sv | 143 ++++++++++++++
 tb/tb_vend_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, product selection, dispenser req/ack
// handshake with timeout refund, and quarter-by-quarter change payout.
module vend_controller #(
  parameter int PRICE0       = 4,
  parameter int PRICE1       = 5,
  parameter int PRICE2       = 6,
  parameter int PRICE3       = 8,
  parameter int MAX_CREDIT   = 20,
  parameter int CW           = 5,
  parameter int DISP_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Quarter,
  input  logic          Doller,
  input  logic          sel_valid,
  input  logic [1:0]    sel,
  input  logic          cancel,
  input  logic          disp_ack,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          disp_req,
  output logic [1:0]    disp_id,
  output logic          change,
  output logic          coin_reject,
  output logic          insufficient,
  output logic          fault
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam int TW = $clog2(DISP_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic          disp_req_nxt;
  logic [1:0]    disp_id_nxt;
  logic          change_nxt, coin_reject_nxt, insufficient_nxt, fault_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          phase, phase_nxt;
  logic          coin;
  logic [CW-1:0] add, sel_price, id_price;

  function automatic logic [CW-1:0] price(input logic [1:0] idx);
    case (idx)
      2'd0:    price = CW'(PRICE0);
      2'd1:    price = CW'(PRICE1);
      2'd2:    price = CW'(PRICE2);
      default: price = CW'(PRICE3);
    endcase
  endfunction

  assign coin      = Quarter | Doller;
  assign add       = CW'(Quarter) + (Doller ? CW'(4) : CW'(0));
  assign sel_price = price(sel);
  assign id_price  = price(disp_id);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    disp_req_nxt     = disp_req;
    disp_id_nxt      = disp_id;
    change_nxt       = 1'b0;
    coin_reject_nxt  = coin;   // any coin is refused unless accepted below
    insufficient_nxt = 1'b0;
    fault_nxt        = 1'b0;
    timer_nxt        = timer;
    phase_nxt        = phase;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        phase_nxt = 1'b0;
        if (cancel) begin
          if (credit != '0) state_nxt = CHANGE;
        end else if (sel_valid) begin
          if (credit >= sel_price) begin
            credit_nxt   = credit - sel_price;
            disp_id_nxt  = sel;
            disp_req_nxt = 1'b1;
            state_nxt    = VEND;
          end else begin
            insufficient_nxt = 1'b1;
          end
        end else if (coin && (credit + add <= CW'(MAX_CREDIT))) begin
          credit_nxt      = credit + add;
          coin_reject_nxt = 1'b0;
        end
      end
      VEND: begin
        timer_nxt = timer + TW'(1);
        // ack is checked first so it wins over a coincident timeout
        if (disp_req && disp_ack) begin
          disp_req_nxt = 1'b0;
          state_nxt    = (credit != '0) ? CHANGE : IDLE;
        end else if (timer == TW'(DISP_TIMEOUT - 1)) begin
          fault_nxt    = 1'b1;
          disp_req_nxt = 1'b0;
          credit_nxt   = credit + id_price;
          state_nxt    = CHANGE;
        end
      end
      CHANGE: begin
        if (phase) begin
          phase_nxt = 1'b0;
        end else if (credit != '0) begin
          change_nxt = 1'b1;
          credit_nxt = credit - CW'(1);
          phase_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      credit       <= '0;
      disp_req     <= 1'b0;
      disp_id      <= 2'd0;
      change       <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      fault        <= 1'b0;
      timer        <= '0;
      phase        <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      disp_req     <= disp_req_nxt;
      disp_id      <= disp_id_nxt;
      change       <= change_nxt;
      coin_reject  <= coin_reject_nxt;
      insufficient <= insufficient_nxt;
      fault        <= fault_nxt;
      timer        <= timer_nxt;
      phase        <= phase_nxt;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios then random traffic, checked
// against a timeline model built from the credit and payout timing rules.
module tb_vend_controller;
  localparam int CW   = 5;
  localparam int TO   = 16;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          rst_n, Quarter, Doller, sel_valid, cancel, disp_ack;
  logic [1:0]    sel;
  logic [CW-1:0] credit;
  logic          busy, disp_req, change, coin_reject, insufficient, fault;
  logic [1:0]    disp_id;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk(clk), .rst_n(rst_n), .Quarter(Quarter), .Doller(Doller),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .disp_ack(disp_ack),
    .credit(credit), .busy(busy), .disp_req(disp_req), .disp_id(disp_id),
    .change(change), .coin_reject(coin_reject), .insufficient(insufficient),
    .fault(fault)
  );

  int n_chk = 0, n_pass = 0;
  int prices [4] = '{4, 5, 6, 8};

  // model: mode 0 idle, 1 waiting on dispenser, 2 paying out pay_n quarters from edge t_pay
  int m_mode = 0, m_credit = 0, m_id = 0;
  int t_vend = 0, t_pay = 0, pay_n = 0, edge_no = 0;
  bit e_chg, e_rej, e_ins, e_flt;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
  endtask

  task automatic model_step(input bit r, q, d, sv, input int s, input bit c, a);
    int k;
    bit coin;
    edge_no++;
    e_chg = 0; e_rej = 0; e_ins = 0; e_flt = 0;
    coin = q | d;
    if (!r) begin
      m_mode = 0; m_credit = 0; m_id = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (c) begin
          e_rej = coin;
          if (m_credit > 0) begin m_mode = 2; t_pay = edge_no; pay_n = m_credit; end
        end else if (sv) begin
          e_rej = coin;
          if (m_credit >= prices[s]) begin
            m_credit -= prices[s]; m_id = s; m_mode = 1; t_vend = edge_no;
          end else e_ins = 1;
        end else if (coin) begin
          if (m_credit + q + 4 * d <= MAXC) m_credit += q + 4 * d;
          else e_rej = 1;
        end
      end
      1: begin
        e_rej = coin;
        if (a) begin
          if (m_credit > 0) begin m_mode = 2; t_pay = edge_no; pay_n = m_credit; end
          else m_mode = 0;
        end else if (edge_no - t_vend == TO) begin
          e_flt = 1;
          m_credit += prices[m_id];
          m_mode = 2; t_pay = edge_no; pay_n = m_credit;
        end
      end
      default: begin
        e_rej = coin;
        k = edge_no - t_pay;
        if (k > 2 * pay_n) begin
          m_mode = 0; m_credit = 0;
        end else begin
          e_chg = (k % 2 == 1);
          m_credit = pay_n - (k + 1) / 2;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit r, q, d, sv, input int s, input bit c, a);
    rst_n = r; Quarter = q; Doller = d; sel_valid = sv; sel = 2'(s);
    cancel = c; disp_ack = a;
    @(posedge clk);
    model_step(r, q, d, sv, s, c, a);
    @(negedge clk);
    chk("credit",       int'(credit),       m_credit);
    chk("busy",         int'(busy),         int'(m_mode != 0));
    chk("disp_req",     int'(disp_req),     int'(m_mode == 1));
    chk("disp_id",      int'(disp_id),      m_id);
    chk("change",       int'(change),       int'(e_chg));
    chk("coin_reject",  int'(coin_reject),  int'(e_rej));
    chk("insufficient", int'(insufficient), int'(e_ins));
    chk("fault",        int'(fault),        int'(e_flt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    // reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);

    // exact pay
    cycle(1, 0, 1, 0, 0, 0, 0);  chk("pay_c4", int'(credit), 4);
    cycle(1, 1, 0, 0, 0, 0, 0);  chk("pay_c5", int'(credit), 5);
    cycle(1, 0, 0, 1, 1, 0, 0);
    chk("pay_req", int'(disp_req), 1); chk("pay_id", int'(disp_id), 1);
    chk("pay_c0", int'(credit), 0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 1);  chk("pay_idle", int'(busy), 0);
    idle(2);

    // change of 4
    cycle(1, 0, 1, 0, 0, 0, 0); cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);  chk("chg_c4", int'(credit), 4);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin idle(1); cnt += int'(change); end
    chk("chg_cnt", cnt, 4); chk("chg_busy", int'(busy), 0);

    // credit ceiling, then drain by cancel
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    chk("lim_c20", int'(credit), 20);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("lim_rej", int'(coin_reject), 1); chk("lim_hold", int'(credit), 20);
    cycle(1, 0, 0, 0, 0, 1, 0);
    idle(41);
    // insufficient
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 3, 0, 0);
    chk("ins_pulse", int'(insufficient), 1); chk("ins_c3", int'(credit), 3);
    idle(1); chk("ins_width", int'(insufficient), 0);
    // coin during vend
    cycle(1, 1, 0, 0, 0, 0, 0); cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("vend_rej", int'(coin_reject), 1); chk("vend_c0", int'(credit), 0);
    cycle(1, 0, 0, 0, 0, 0, 1);

    // dispenser timeout
    cycle(1, 0, 1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 2, 0, 0);
    idle(TO - 1); chk("to_early", int'(fault), 0);
    idle(1);
    chk("to_fault", int'(fault), 1); chk("to_req", int'(disp_req), 0);
    chk("to_c6", int'(credit), 6);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin idle(1); cnt += int'(change); end
    chk("to_cnt", cnt, 6); chk("to_busy", int'(busy), 0);

    // cancel with coin in same cycle
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0);  chk("can_rej", int'(coin_reject), 1);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin idle(1); cnt += int'(change); end
    chk("can_cnt", cnt, 3);

    // reset mid-payout
    cycle(1, 0, 1, 0, 0, 0, 0); cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("mrst_c", int'(credit), 0); chk("mrst_busy", int'(busy), 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
